// File: rtl/spi_xfer_ctrl.sv
// Single-byte SPI master transfer controller: CS lead, 16 SCK edges, CS lag.
// Mode (cpol/cpha), divider and data are latched at start and held for the whole transfer.
module spi_xfer_ctrl #(
    parameter int unsigned DIVW = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [DIVW-1:0] divider,
    input  logic            cpol,
    input  logic            cpha,
    input  logic            start,
    input  logic [7:0]      tx_data,
    input  logic            MISO,
    output logic            busy,
    output logic            done,
    output logic [7:0]      rx_data,
    output logic            SCK,
    output logic            MOSI,
    output logic            CS_n
);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t          state_q;
    logic [DIVW-1:0] cnt_q;
    logic [DIVW-1:0] div_q;
    logic            cpol_q;
    logic            cpha_q;
    logic [4:0]      edge_q;
    logic [7:0]      tx_sh_q;
    logic [7:0]      rx_sh_q;
    logic [7:0]      rx_data_q;
    logic            sck_q;
    logic            mosi_q;
    logic            cs_n_q;
    logic            done_q;

    logic            tick;
    logic [4:0]      edge_d;
    logic            sample_en;
    logic            shift_en;

    always_comb begin
        tick   = (cnt_q == div_q);
        edge_d = edge_q + 5'd1;
        // cpha=0: sample odd edges, shift even edges except the last;
        // cpha=1: sample even edges, shift odd edges except the first.
        if (cpha_q) begin
            sample_en = ~edge_d[0];
            shift_en  = edge_d[0] && (edge_d != 5'd1);
        end else begin
            sample_en = edge_d[0];
            shift_en  = ~edge_d[0] && (edge_d != 5'd16);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            edge_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    edge_q <= '0;
                    sck_q  <= cpol_q;
                    mosi_q <= 1'b0;
                    cs_n_q <= 1'b1;
                    if (start) begin
                        state_q <= SETUP;
                        div_q   <= divider;
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        sck_q   <= cpol;
                        tx_sh_q <= tx_data;
                        mosi_q  <= tx_data[7];
                        rx_sh_q <= '0;
                        cs_n_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        state_q <= XFER;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                XFER: begin
                    if (tick) begin
                        cnt_q  <= '0;
                        sck_q  <= ~sck_q;
                        edge_q <= edge_d;
                        if (sample_en) rx_sh_q <= {rx_sh_q[6:0], MISO};
                        if (shift_en) begin
                            tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                            mosi_q  <= tx_sh_q[6];
                        end
                        if (edge_d == 5'd16) state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                        cs_n_q    <= 1'b1;
                        mosi_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sh_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign SCK     = sck_q;
    assign MOSI    = mosi_q;
    assign CS_n    = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: one 32-bit-divider instance and one 4-bit-divider instance.
module tb_spi_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] divider;
    logic        cpol, cpha, start;
    logic [7:0]  tx_data;
    logic        miso, miso_val, loop_en;
    logic        busy, done, sck, mosi, cs_n;
    logic [7:0]  rx_data;

    assign miso = loop_en ? mosi : miso_val;

    spi_xfer_ctrl u_dut (
        .CLK(clk), .RST(rst), .divider(divider), .cpol(cpol), .cpha(cpha),
        .start(start), .tx_data(tx_data), .MISO(miso), .busy(busy), .done(done),
        .rx_data(rx_data), .SCK(sck), .MOSI(mosi), .CS_n(cs_n)
    );

    logic [3:0]  div4;
    logic        cpol4, cpha4, start4;
    logic [7:0]  tx4;
    logic        busy4, done4, sck4, mosi4, cs4;
    logic [7:0]  rx4;

    spi_xfer_ctrl #(.DIVW(4)) u_dut4 (
        .CLK(clk), .RST(rst), .divider(div4), .cpol(cpol4), .cpha(cpha4),
        .start(start4), .tx_data(tx4), .MISO(mosi4), .busy(busy4), .done(done4),
        .rx_data(rx4), .SCK(sck4), .MOSI(mosi4), .CS_n(cs4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Called on a negedge; leaves start high if hold is set.
    task automatic kick(input logic [31:0] d, input logic c_pol, input logic c_pha,
                        input logic [7:0] tx, input bit hold);
        divider = d; cpol = c_pol; cpha = c_pha; tx_data = tx; start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Observes from the first SETUP cycle up to and including the done cycle.
    task automatic run_xfer(input int max_cyc, input int glitch_at,
                            output int bcyc, output int rises, output int ndone,
                            output logic [7:0] mseq, output logic first_cs,
                            output logic first_mosi);
        logic prev_sck;
        bcyc = 0; rises = 0; ndone = 0; mseq = '0;
        first_cs = cs_n; first_mosi = mosi; prev_sck = sck;
        for (int k = 0; k < max_cyc; k++) begin
            if (busy) bcyc++;
            if (done) ndone++;
            if (sck && !prev_sck) begin
                rises++;
                mseq = {mseq[6:0], mosi};
            end
            prev_sck = sck;
            if (done) break;
            if (glitch_at >= 0 && k == glitch_at) begin
                start = 1'b1; tx_data = 8'hFF; divider = '0; cpha = ~cpha;
            end
            if (glitch_at >= 0 && k == glitch_at + 1) start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcyc, rises, ndone, chg, hi;
        logic [7:0] mseq;
        logic fcs, fmosi, prev;

        divider = '0; cpol = 1'b0; cpha = 1'b0; start = 1'b0; tx_data = '0;
        miso_val = 1'b0; loop_en = 1'b0;
        div4 = '0; cpol4 = 1'b0; cpha4 = 1'b0; start4 = 1'b0; tx4 = '0;

        repeat (3) @(negedge clk);
        check("rst_sck",   sck,     1'b0);
        check("rst_mosi",  mosi,    1'b0);
        check("rst_cs_n",  cs_n,    1'b1);
        check("rst_busy",  busy,    1'b0);
        check("rst_done",  done,    1'b0);
        check("rst_rx",    rx_data, 8'h00);
        check("rst_busy4", busy4,   1'b0);
        rst = 1'b0;
        @(negedge clk);

        // divider=1, mode 0, loopback
        loop_en = 1'b1;
        kick(32'd1, 1'b0, 1'b0, 8'hA5, 1'b0);
        run_xfer(200, -1, bcyc, rises, ndone, mseq, fcs, fmosi);
        check("t1_cs_setup",   fcs,     1'b0);
        check("t1_mosi_setup", fmosi,   1'b1);
        check("t1_busy_cyc",   bcyc,    32'd36);
        check("t1_rises",      rises,   32'd8);
        check("t1_done",       ndone,   32'd1);
        check("t1_rx",         rx_data, 8'hA5);
        check("t1_mosi_seq",   mseq,    8'hA5);
        check("t1_cs_idle",    cs_n,    1'b1);
        @(negedge clk);
        check("t1_done_once",  done,    1'b0);
        check("t1_sck_idle",   sck,     1'b0);
        check("t1_mosi_idle",  mosi,    1'b0);

        // divider=0, mode 3, MISO tied high
        loop_en = 1'b0; miso_val = 1'b1;
        kick(32'd0, 1'b1, 1'b1, 8'h3C, 1'b0);
        check("t2_sck_setup",  sck,     1'b1);
        run_xfer(100, -1, bcyc, rises, ndone, mseq, fcs, fmosi);
        check("t2_busy_cyc",   bcyc,    32'd18);
        check("t2_done",       ndone,   32'd1);
        check("t2_rx",         rx_data, 8'hFF);
        check("t2_mosi_seq",   mseq,    8'h3C);
        @(negedge clk);
        check("t2_sck_idle",   sck,     1'b1);

        // restart mid-transfer must be ignored
        loop_en = 1'b1;
        kick(32'd1, 1'b0, 1'b0, 8'h5A, 1'b0);
        run_xfer(200, 10, bcyc, rises, ndone, mseq, fcs, fmosi);
        check("t3_busy_cyc",   bcyc,    32'd36);
        check("t3_done",       ndone,   32'd1);
        check("t3_rx",         rx_data, 8'h5A);
        check("t3_mosi_seq",   mseq,    8'h5A);
        @(negedge clk);
        check("t3_no_restart", busy,    1'b0);
        check("t3_done_once",  done,    1'b0);

        // reset when edge 9 is due
        kick(32'd1, 1'b1, 1'b0, 8'h81, 1'b0);
        chg = 0; prev = sck;
        for (int k = 0; k < 200 && chg < 8; k++) begin
            @(negedge clk);
            if (sck != prev) chg++;
            prev = sck;
        end
        check("t4_edges_seen", chg,     32'd8);
        @(negedge clk);
        check("t4_busy_pre",   busy,    1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_cs_n",       cs_n,    1'b1);
        check("t4_busy",       busy,    1'b0);
        check("t4_sck",        sck,     1'b0);
        check("t4_done",       done,    1'b0);
        check("t4_rx",         rx_data, 8'h00);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t4_no_done",    ndone,   32'd0);
        check("t4_rx_held",    rx_data, 8'h00);

        // start held high: back-to-back transfers
        kick(32'd2, 1'b0, 1'b1, 8'hC3, 1'b1);
        run_xfer(200, -1, bcyc, rises, ndone, mseq, fcs, fmosi);
        check("t5_busy_cyc_a", bcyc,    32'd54);
        check("t5_done_a",     ndone,   32'd1);
        check("t5_rx_a",       rx_data, 8'hC3);
        @(negedge clk);
        check("t5_restart",    busy,    1'b1);
        check("t5_pulse_len",  done,    1'b0);
        run_xfer(200, -1, bcyc, rises, ndone, mseq, fcs, fmosi);
        start = 1'b0;
        check("t5_busy_cyc_b", bcyc,    32'd54);
        check("t5_done_b",     ndone,   32'd1);
        check("t5_rx_b",       rx_data, 8'hC3);
        @(negedge clk);
        check("t5_stop",       busy,    1'b0);

        // 4-bit divider at all-ones
        div4 = 4'hF; tx4 = 8'h96; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        bcyc = 0; hi = 0; ndone = 0;
        for (int k = 0; k < 400; k++) begin
            if (busy4) bcyc++;
            if (busy4 && sck4) hi++;
            if (done4) begin
                ndone++;
                break;
            end
            @(negedge clk);
        end
        check("t6_busy_cyc",   bcyc,    32'd288);
        check("t6_sck_high",   hi,      32'd128);
        check("t6_done",       ndone,   32'd1);
        check("t6_rx",         rx4,     8'h96);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DIVW, default 32: width of the divider input.
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port divider, input, DIVW: one SCK half-period lasts divider+1 CLK cycles.
REQ-005 SHALL have port cpol, input, 1: SCK idle level.
REQ-006 SHALL have port cpha, input, 1: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-007 SHALL have port start, input, 1: transfer request, sampled only in IDLE.
REQ-008 SHALL have port tx_data, input, 8: byte to send, MSB first.
REQ-009 SHALL have port MISO, input, 1: serial data in.
REQ-010 SHALL have port busy, output, 1: high in SETUP, XFER and HOLD.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port rx_data, output, 8: last received byte.
REQ-013 SHALL have port SCK, output, 1: serial clock.
REQ-014 SHALL have port MOSI, output, 1: serial data out.
REQ-015 SHALL have port CS_n, output, 1: active-low chip select.

Function
REQ-016 SHALL implement states IDLE, SETUP, XFER, HOLD; busy = (state != IDLE).
REQ-017 SHALL, in IDLE with start=1, latch divider, cpol, cpha and tx_data, enter SETUP next cycle, and assert CS_n=0 and busy=1 from that cycle.
REQ-018 SHALL ignore start in every non-IDLE state, including any change to the latched configuration or data.
REQ-019 SHALL keep a half-period counter that clears on every state entry and increments each cycle; tick = (count == latched divider), after which count returns to 0.
REQ-020 SHALL leave SETUP on tick and enter XFER (CS lead time of one half-period).
REQ-021 SHALL, in XFER, toggle SCK on each tick and count edges 1..16; the tick producing edge 16 moves to HOLD, with SCK then back at cpol.
REQ-022 SHALL leave HOLD on tick, enter IDLE, set CS_n=1, and pulse done=1 for exactly that first IDLE cycle.
REQ-023 SHALL accept a start arriving in the done cycle, since the block is already in IDLE.
REQ-024 SHALL present bit 7 on MOSI from SETUP entry.
REQ-025 SHALL, when cpha=0, sample MISO on odd edges 1,3..15 and shift MOSI on even edges 2..14.
REQ-026 SHALL, when cpha=1, shift MOSI on odd edges 3..15 and sample MISO on even edges 2..16.
REQ-027 SHALL shift samples in MSB first and load rx_data in the same cycle done rises; rx_data SHALL be held otherwise.
REQ-028 SHALL drive SCK=latched cpol and MOSI=0 in IDLE; an SCK edge means a change of the SCK register.
REQ-029 SHALL keep busy high for exactly 18*(divider+1) cycles per transfer; divider=0 gives 18 cycles.
REQ-030 SHALL compare counter and divider at DIVW bits with no overflow; divider = all-ones is legal.

Reset
REQ-031 SHALL, while RST=1 at a clock edge, enter IDLE with SCK=0, MOSI=0, CS_n=1, busy=0, done=0, rx_data=0x00, latched cpol=0, and counters 0.
REQ-032 SHALL abort a transfer on reset mid-operation with no done pulse and no rx_data update.

Verification
REQ-033 SHALL cover: divider=1, cpol=0, cpha=0, tx=0xA5, MISO looped to MOSI -> busy 36 cycles, 8 SCK rising edges, done once, rx_data=0xA5.
REQ-034 SHALL cover: divider=0, cpol=1, cpha=1, tx=0x3C, MISO=1 -> SCK idles high, busy 18 cycles, rx_data=0xFF, MOSI bit sequence 0,0,1,1,1,1,0,0.
REQ-035 SHALL cover: start pulsed again mid-transfer with tx=0xFF -> ignored; original byte completes and only one done occurs.
REQ-036 SHALL cover: RST=1 at edge 9 of a transfer -> next cycle CS_n=1, busy=0, SCK=0, no done, rx_data=0x00.
REQ-037 SHALL cover: start held high continuously with divider=2 -> back-to-back transfers, each busy for 54 cycles, separated by exactly one IDLE (done) cycle.
REQ-038 SHALL cover: divider=all-ones, DIVW=4 -> half-period of 16 cycles, busy 288 cycles, with no counter wrap error.
